snake_pixel_renderer: RTL and testbench

- Upstream pixel source for the VGA timing stage; drives its 8-bit RRRGGGBB pixel input from the scanned X/Y coordinates.
- Holds the snake body as a segment shift register on a 40x30 grid of 16x16-pixel cells, plus border and target.
- Body updates requested by game logic are deferred to the start of vertical blank, so no frame tears.
- 2-stage registered pipeline with built-in 2-pixel lookahead, so the output stays aligned with the current coordinate.

---
 rtl/snake_pixel_renderer_pkg.sv | 36 +++
 rtl/snake_segment_store.sv | 61 ++++++
 rtl/snake_pixel_renderer.sv | 119 +++++++++++
 tb/tb_snake_pixel_renderer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pixel_renderer_pkg.sv
// Shared constants and types for the snake pixel renderer.
package snake_pixel_renderer_pkg;

   // Grid geometry: 40x30 cells of 16x16 pixels
   localparam int unsigned CELL_SHIFT = 4;
   localparam int unsigned GRID_W     = 40;
   localparam int unsigned GRID_H     = 30;

   // VGA 640x480 timing totals
   localparam int unsigned H_TOTAL = 800;
   localparam int unsigned V_TOTAL = 525;
   localparam int unsigned H_VIS   = 640;
   localparam int unsigned V_VIS   = 480;

   // Field widths
   localparam int unsigned COORD_W = 11;
   localparam int unsigned CX_W    = 6;
   localparam int unsigned CY_W    = 5;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned LEN_W   = 5;

   // RRRGGGBB colours
   localparam logic [PIX_W-1:0] COL_BLANK  = 8'h00;
   localparam logic [PIX_W-1:0] COL_BORDER = 8'h03;
   localparam logic [PIX_W-1:0] COL_HEAD   = 8'hFC;
   localparam logic [PIX_W-1:0] COL_DEAD   = 8'hE0;
   localparam logic [PIX_W-1:0] COL_BODY   = 8'h1C;
   localparam logic [PIX_W-1:0] COL_TARGET = 8'hE3;

   // One snake segment: cell column and row
   typedef struct packed {
      logic [CX_W-1:0] x;
      logic [CY_W-1:0] y;
   } seg_t;

endpackage

// File: rtl/snake_segment_store.sv
// Snake body shift register with frame-synchronous step/grow application.
module snake_segment_store
   import snake_pixel_renderer_pkg::*;
#(
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned START_X  = 20,
   parameter int unsigned START_Y  = 15
) (
   input  logic                     CLK25MHz,
   input  logic                     RESET_N,
   input  logic                     apply_c,
   input  logic                     STEP,
   input  logic                     GROW,
   input  logic [CX_W-1:0]          HEAD_X,
   input  logic [CY_W-1:0]          HEAD_Y,
   output seg_t [MAX_LEN-1:0]       seg,
   output logic [LEN_W-1:0]         LENGTH,
   output logic                     STEP_ACK
);

   logic step_pending;
   logic grow_pending;
   seg_t head_hold;

   // Capture requests any time; shift the body only at the apply point
   always_ff @(posedge CLK25MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg[i].x <= CX_W'(START_X - i);
            seg[i].y <= CY_W'(START_Y);
         end
         LENGTH       <= LEN_W'(INIT_LEN);
         STEP_ACK     <= 1'b0;
         step_pending <= 1'b0;
         grow_pending <= 1'b0;
         head_hold    <= '0;
      end else begin
         STEP_ACK <= 1'b0;
         if (apply_c && step_pending) begin
            seg          <= {seg[MAX_LEN-2:0], head_hold};
            step_pending <= 1'b0;
            STEP_ACK     <= 1'b1;
            if (grow_pending) begin
               grow_pending <= 1'b0;
               if (LENGTH < LEN_W'(MAX_LEN))
                  LENGTH <= LENGTH + LEN_W'(1);
            end
         end
         // First request wins; a step seen on the apply cycle waits a frame
         if (STEP && !step_pending) begin
            step_pending <= 1'b1;
            head_hold.x  <= HEAD_X;
            head_hold.y  <= HEAD_Y;
         end
         if (GROW)
            grow_pending <= 1'b1;
      end
   end

endmodule

// File: rtl/snake_pixel_renderer.sv
// Two-stage colour pipeline for the snake game, running 2 pixels ahead of the scan.
module snake_pixel_renderer
   import snake_pixel_renderer_pkg::*;
#(
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned START_X  = 20,
   parameter int unsigned START_Y  = 15
) (
   input  logic                 CLK25MHz,
   input  logic                 RESET_N,
   input  logic [COORD_W-1:0]   XCoord,
   input  logic [COORD_W-1:0]   YCoord,
   input  logic [CX_W-1:0]      HEAD_X,
   input  logic [CY_W-1:0]      HEAD_Y,
   input  logic                 STEP,
   input  logic                 GROW,
   input  logic [CX_W-1:0]      TARGET_X,
   input  logic [CY_W-1:0]      TARGET_Y,
   input  logic                 DEAD,
   output logic [PIX_W-1:0]     PIXEL_OUT,
   output logic [LEN_W-1:0]     LENGTH,
   output logic                 STEP_ACK
);

   seg_t [MAX_LEN-1:0]  seg;
   logic                apply_c;
   logic [COORD_W-1:0]  x_sum_c;
   logic [COORD_W-1:0]  x_la_c;
   logic [COORD_W-1:0]  y_la_c;
   logic [CX_W-1:0]     cx;
   logic [CY_W-1:0]     cy;
   logic                vis;
   logic                hit_border_c;
   logic                hit_head_c;
   logic                hit_body_c;
   logic                hit_target_c;
   logic [PIX_W-1:0]    colour_c;

   // First pixel of vertical blank
   assign apply_c = (XCoord == '0) && (YCoord == COORD_W'(V_VIS));

   snake_segment_store #(
      .MAX_LEN  (MAX_LEN),
      .INIT_LEN (INIT_LEN),
      .START_X  (START_X),
      .START_Y  (START_Y)
   ) u_store (
      .CLK25MHz (CLK25MHz),
      .RESET_N  (RESET_N),
      .apply_c  (apply_c),
      .STEP     (STEP),
      .GROW     (GROW),
      .HEAD_X   (HEAD_X),
      .HEAD_Y   (HEAD_Y),
      .seg      (seg),
      .LENGTH   (LENGTH),
      .STEP_ACK (STEP_ACK)
   );

   // Coordinate two pixels ahead, wrapping across line and frame ends
   always_comb begin
      x_sum_c = XCoord + COORD_W'(2);
      x_la_c  = x_sum_c;
      y_la_c  = YCoord;
      if (x_sum_c >= COORD_W'(H_TOTAL)) begin
         x_la_c = x_sum_c - COORD_W'(H_TOTAL);
         y_la_c = YCoord + COORD_W'(1);
         if (y_la_c >= COORD_W'(V_TOTAL))
            y_la_c = '0;
      end
   end

   // Stage 1: cell index and visibility of the lookahead pixel
   always_ff @(posedge CLK25MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         cx  <= '0;
         cy  <= '0;
         vis <= 1'b0;
      end else begin
         cx  <= x_la_c[CELL_SHIFT +: CX_W];
         cy  <= y_la_c[CELL_SHIFT +: CY_W];
         vis <= (x_la_c < COORD_W'(H_VIS)) && (y_la_c < COORD_W'(V_VIS));
      end
   end

   // Cell hit tests and colour priority
   always_comb begin
      hit_border_c = (cx == '0) || (cx == CX_W'(GRID_W - 1)) ||
                     (cy == '0) || (cy == CY_W'(GRID_H - 1));
      hit_head_c   = (seg[0].x == cx) && (seg[0].y == cy);
      hit_target_c = (TARGET_X == cx) && (TARGET_Y == cy);
      hit_body_c   = 1'b0;
      for (int i = 1; i < int'(MAX_LEN); i++) begin
         if ((LEN_W'(i) < LENGTH) && (seg[i].x == cx) && (seg[i].y == cy))
            hit_body_c = 1'b1;
      end
      colour_c = COL_BLANK;
      if (!vis)
         colour_c = COL_BLANK;
      else if (hit_border_c)
         colour_c = COL_BORDER;
      else if (hit_head_c)
         colour_c = DEAD ? COL_DEAD : COL_HEAD;
      else if (hit_body_c)
         colour_c = COL_BODY;
      else if (hit_target_c)
         colour_c = COL_TARGET;
   end

   // Stage 2: registered pixel colour
   always_ff @(posedge CLK25MHz or negedge RESET_N) begin
      if (!RESET_N)
         PIXEL_OUT <= '0;
      else
         PIXEL_OUT <= colour_c;
   end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Self-checking bench for snake_pixel_renderer.
module tb_snake_pixel_renderer;

   logic        CLK25MHz = 1'b0;
   logic        RESET_N;
   logic [10:0] XCoord;
   logic [10:0] YCoord;
   logic [5:0]  HEAD_X;
   logic [4:0]  HEAD_Y;
   logic        STEP;
   logic        GROW;
   logic [5:0]  TARGET_X;
   logic [4:0]  TARGET_Y;
   logic        DEAD;
   logic [7:0]  PIXEL_OUT;
   logic [4:0]  LENGTH;
   logic        STEP_ACK;

   snake_pixel_renderer dut (
      .CLK25MHz  (CLK25MHz),
      .RESET_N   (RESET_N),
      .XCoord    (XCoord),
      .YCoord    (YCoord),
      .HEAD_X    (HEAD_X),
      .HEAD_Y    (HEAD_Y),
      .STEP      (STEP),
      .GROW      (GROW),
      .TARGET_X  (TARGET_X),
      .TARGET_Y  (TARGET_Y),
      .DEAD      (DEAD),
      .PIXEL_OUT (PIXEL_OUT),
      .LENGTH    (LENGTH),
      .STEP_ACK  (STEP_ACK)
   );

   always #20 CLK25MHz = ~CLK25MHz;

   typedef struct {
      logic [7:0] exp;
      string      name;
   } sb_t;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] exp;
      string      name;
   } vec_t;

   sb_t  q[$];
   vec_t vt[8];
   int   total = 0;
   int   bad   = 0;
   int   ack_seen = 0;

   // Reference model of the snake state
   int m_sx[16];
   int m_sy[16];
   int m_len;
   int m_hx, m_hy;
   bit m_sp, m_gp;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_sx[i] = 20 - i;
         m_sy[i] = 15;
      end
      m_len = 3;
      m_sp  = 0;
      m_gp  = 0;
      m_hx  = 0;
      m_hy  = 0;
   endtask

   function automatic logic [7:0] model_pix(input int px, input int py);
      int cx, cy;
      cx = px / 16;
      cy = py / 16;
      if (px >= 640 || py >= 480) return 8'h00;
      if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 8'h03;
      if (m_sx[0] == cx && m_sy[0] == cy) return DEAD ? 8'hE0 : 8'hFC;
      for (int i = 1; i < m_len; i++)
         if (m_sx[i] == cx && m_sy[i] == cy) return 8'h1C;
      if (int'(TARGET_X) == cx && int'(TARGET_Y) == cy) return 8'hE3;
      return 8'h00;
   endfunction

   // Colour the DUT must show two cycles after being driven with (x,y)
   function automatic logic [7:0] model_exp(input int x, input int y);
      int px, py;
      px = x + 2;
      py = y;
      if (px >= 800) begin
         px -= 800;
         py = y + 1;
         if (py >= 525) py = 0;
      end
      return model_pix(px, py);
   endfunction

   // One clock: drive coordinates, push expected colour, update model, pop and compare
   task automatic drive(input int x, input int y, input logic [7:0] exp, input string nm);
      sb_t e;
      bit  sp_old, exp_ack;
      XCoord = 11'(x);
      YCoord = 11'(y);
      e.exp  = exp;
      e.name = nm;
      q.push_back(e);
      sp_old  = m_sp;
      exp_ack = 0;
      if (x == 0 && y == 480 && sp_old) begin
         for (int i = 15; i > 0; i--) begin
            m_sx[i] = m_sx[i-1];
            m_sy[i] = m_sy[i-1];
         end
         m_sx[0] = m_hx;
         m_sy[0] = m_hy;
         m_sp    = 0;
         exp_ack = 1;
         if (m_gp) begin
            m_gp = 0;
            if (m_len < 16) m_len++;
         end
      end
      if (GROW) m_gp = 1;
      if (STEP && !sp_old) begin
         m_sp = 1;
         m_hx = int'(HEAD_X);
         m_hy = int'(HEAD_Y);
      end
      @(posedge CLK25MHz);
      #1;
      if (STEP_ACK === 1'b1) ack_seen++;
      check({"step_ack ", nm}, 32'(STEP_ACK), 32'(exp_ack));
      check({"length ", nm}, 32'(LENGTH), 32'(m_len));
      if (q.size() >= 2) begin
         e = q.pop_front();
         check({"pixel ", e.name}, 32'(PIXEL_OUT), 32'(e.exp));
      end
   endtask

   task automatic mdrive(input int x, input int y, input string nm);
      drive(x, y, model_exp(x, y), nm);
   endtask

   // Invisible lookahead; safe slot before changing TARGET/DEAD
   task automatic flush();
      mdrive(700, 100, "flush");
      mdrive(700, 100, "flush");
   endtask

   task automatic pulse(input bit s, input bit g, input int hx, input int hy,
                        input int x, input int y);
      STEP   = s;
      GROW   = g;
      HEAD_X = 6'(hx);
      HEAD_Y = 5'(hy);
      mdrive(x, y, "pulse");
      STEP = 0;
      GROW = 0;
   endtask

   task automatic apply_frame();
      mdrive(0, 480, "apply");
      mdrive(1, 480, "post_apply");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{318, 240, 8'hFC, "head_20_15"};
      vt[1] = '{302, 240, 8'h1C, "body_19_15"};
      vt[2] = '{270, 240, 8'h00, "beyond_len_17"};
      vt[3] = '{798, 524, 8'h03, "frame_wrap_0_0"};
      vt[4] = '{637, 479, 8'h03, "corner_639_479"};
      vt[5] = '{698, 100, 8'h00, "hblank_700_100"};
      vt[6] = '{798, 10,  8'h03, "line_wrap_0_11"};
      vt[7] = '{158, 160, 8'hE3, "target_10_10"};

      RESET_N  = 0;
      XCoord   = 11'd700;
      YCoord   = 11'd100;
      HEAD_X   = '0;
      HEAD_Y   = '0;
      STEP     = 0;
      GROW     = 0;
      TARGET_X = 6'd10;
      TARGET_Y = 5'd10;
      DEAD     = 0;
      model_reset();
      repeat (3) @(posedge CLK25MHz);
      #1;
      check("rst_pixel", 32'(PIXEL_OUT), 32'h00);
      check("rst_length", 32'(LENGTH), 32'd3);
      check("rst_ack", 32'(STEP_ACK), 32'd0);
      @(negedge CLK25MHz);
      RESET_N = 1;

      for (int i = 0; i < 8; i++)
         drive(vt[i].x, vt[i].y, vt[i].exp, vt[i].name);
      flush();

      // Step deferred to vertical blank
      pulse(1, 0, 21, 15, 0, 100);
      drive(334, 240, 8'h00, "pre_apply_cell21");
      drive(286, 240, 8'h1C, "pre_apply_cell18");
      flush();
      ack_seen = 0;
      apply_frame();
      check("step_ack_count", 32'(ack_seen), 32'd1);
      drive(334, 240, 8'hFC, "post_apply_cell21");
      drive(286, 240, 8'h00, "post_apply_cell18");
      flush();

      // Grow then step
      pulse(0, 1, 0, 0, 0, 50);
      pulse(1, 0, 22, 15, 0, 51);
      apply_frame();
      check("grow_len4", 32'(LENGTH), 32'd4);
      drive(302, 240, 8'h1C, "grown_cell19");
      flush();

      // Grow to saturation
      for (int k = 0; k < 14; k++) begin
         pulse(1, 1, 23 + k, 15, 0, 60);
         apply_frame();
         check("sat_len", 32'(LENGTH), 32'((5 + k > 16) ? 16 : 5 + k));
      end
      drive(334, 240, 8'h1C, "tail_cell21");
      drive(318, 240, 8'h00, "past_tail_cell20");
      flush();

      // Two steps in one frame: first wins
      pulse(1, 0, 5, 5, 0, 60);
      pulse(1, 0, 6, 6, 0, 61);
      ack_seen = 0;
      apply_frame();
      check("two_step_acks", 32'(ack_seen), 32'd1);
      drive(78, 80, 8'hFC, "two_step_head_5_5");
      drive(94, 96, 8'h00, "two_step_drop_6_6");
      flush();
      ack_seen = 0;
      apply_frame();
      check("idle_frame_acks", 32'(ack_seen), 32'd0);
      drive(94, 96, 8'h00, "idle_frame_6_6");
      flush();

      // Step arriving on the apply cycle waits a frame
      STEP   = 1;
      HEAD_X = 6'd7;
      HEAD_Y = 5'd7;
      mdrive(0, 480, "step_on_apply");
      STEP = 0;
      mdrive(1, 480, "after_step_on_apply");
      drive(110, 112, 8'h00, "held_not_drawn_7_7");
      flush();
      apply_frame();
      drive(110, 112, 8'hFC, "held_head_7_7");
      flush();

      // Dead colour and target priority
      DEAD = 1;
      drive(158, 160, 8'hE3, "dead_target_10_10");
      drive(110, 112, 8'hE0, "dead_head_7_7");
      flush();
      TARGET_X = 6'd7;
      TARGET_Y = 5'd7;
      drive(110, 112, 8'hE0, "target_on_head");
      mdrive(0, 100, "border_a");
      mdrive(0, 100, "border_b");

      // Asynchronous reset mid-line
      check("pre_reset_pixel", 32'(PIXEL_OUT), 32'h03);
      #5;
      RESET_N = 0;
      #1;
      check("async_rst_pixel", 32'(PIXEL_OUT), 32'h00);
      check("async_rst_length", 32'(LENGTH), 32'd3);
      check("async_rst_ack", 32'(STEP_ACK), 32'd0);
      @(negedge CLK25MHz);
      RESET_N  = 1;
      DEAD     = 0;
      TARGET_X = 6'd10;
      TARGET_Y = 5'd10;
      model_reset();
      q.delete();
      drive(318, 240, 8'hFC, "rst_head_20_15");
      drive(270, 240, 8'h00, "rst_beyond_len");
      flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
